// File: rtl/timebase_phase_meter_if.sv
// Measurement-side bus of the timebase phase meter: control/sync inputs and result strobes.
interface timebase_phase_meter_if #(
    parameter int COUNTER_WIDTH = 16
);
    logic                     enable;
    logic                     ref_sync;
    logic                     local_sync;
    logic [COUNTER_WIDTH-1:0] max_delay;
    logic [COUNTER_WIDTH-1:0] delay_out;
    logic                     delay_valid;
    logic                     timeout;

    modport master (
        output enable, ref_sync, local_sync, max_delay,
        input  delay_out, delay_valid, timeout
    );

    modport slave (
        input  enable, ref_sync, local_sync, max_delay,
        output delay_out, delay_valid, timeout
    );
endinterface

// File: rtl/timebase_phase_meter.sv
// Cycle-count phase offset between ref_sync and local_sync, in timebase-shifter delay units.
// Optional macro TIMEBASE_PHASE_METER_AVERAGE_EN reports the mean of every 4 valid measurements.
module timebase_phase_meter #(
    parameter int COUNTER_WIDTH = 16
) (
    input  logic                    clockIn,
    input  logic                    reset,
    timebase_phase_meter_if.slave   bus
);
    typedef enum logic {IDLE, COUNTING} state_t;

    state_t                   state_q, state_d;
    logic [COUNTER_WIDTH-1:0] count_q, count_d;
    logic [COUNTER_WIDTH-1:0] delay_q, delay_d;
    logic                     valid_q, valid_d;
    logic                     timeout_q, timeout_d;

    // One valid measurement this cycle, and whether the averaging window must be dropped.
    logic                     meas_hit;
    logic [COUNTER_WIDTH-1:0] meas_val;
    logic                     abort;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        timeout_d = 1'b0;
        meas_hit  = 1'b0;
        meas_val  = '0;
        abort     = 1'b0;
        if (!bus.enable) begin
            state_d = IDLE;
            count_d = '0;
            abort   = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.ref_sync && bus.local_sync) begin
                        meas_hit = 1'b1;
                    end else if (bus.ref_sync) begin
                        state_d = COUNTING;
                        count_d = COUNTER_WIDTH'(1);
                    end
                end
                COUNTING: begin
                    if (bus.local_sync) begin
                        meas_hit = 1'b1;
                        meas_val = count_q;
                        if (bus.ref_sync) begin
                            count_d = COUNTER_WIDTH'(1);
                        end else begin
                            state_d = IDLE;
                            count_d = '0;
                        end
                    end else if (bus.ref_sync) begin
                        count_d = COUNTER_WIDTH'(1);
                    end else if (count_q >= bus.max_delay) begin
                        // >= so max_delay==0, or a limit lowered mid-count, still expires
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                        count_d   = '0;
                        abort     = 1'b1;
                    end else begin
                        count_d = count_q + COUNTER_WIDTH'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

`ifdef TIMEBASE_PHASE_METER_AVERAGE_EN
    logic [COUNTER_WIDTH+1:0] sum_q, sum_d;
    logic [1:0]               nsamp_q, nsamp_d;
    logic [COUNTER_WIDTH+1:0] sum_next;

    always_comb begin
        sum_next = sum_q + {2'b00, meas_val};
        sum_d    = sum_q;
        nsamp_d  = nsamp_q;
        delay_d  = delay_q;
        valid_d  = 1'b0;
        if (abort) begin
            sum_d   = '0;
            nsamp_d = '0;
        end else if (meas_hit) begin
            if (nsamp_q == 2'd3) begin
                delay_d = sum_next[COUNTER_WIDTH+1:2];
                valid_d = 1'b1;
                sum_d   = '0;
                nsamp_d = '0;
            end else begin
                sum_d   = sum_next;
                nsamp_d = nsamp_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clockIn) begin
        if (!reset) begin
            sum_q   <= '0;
            nsamp_q <= '0;
        end else begin
            sum_q   <= sum_d;
            nsamp_q <= nsamp_d;
        end
    end
`else
    always_comb begin
        delay_d = delay_q;
        valid_d = 1'b0;
        if (meas_hit) begin
            delay_d = meas_val;
            valid_d = 1'b1;
        end
    end
`endif

    always_ff @(posedge clockIn) begin
        if (!reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            delay_q   <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            delay_q   <= delay_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.delay_out   = delay_q;
    assign bus.delay_valid = valid_q;
    assign bus.timeout     = timeout_q;
endmodule

// File: tb/tb_timebase_phase_meter.sv
// Randomized + directed bench for timebase_phase_meter against a timestamp-based reference model.
module tb_timebase_phase_meter;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    timebase_phase_meter_if #(.COUNTER_WIDTH(CW)) bus();

    timebase_phase_meter #(.COUNTER_WIDTH(CW)) dut (
        .clockIn (clk),
        .reset   (rst_n),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: remembers the cycle index of the arming ref_sync, not a counter.
    longint now      = 0;
    bit     armed    = 0;
    longint t_ref    = 0;
    int     exp_delay = 0;
    bit     exp_valid = 0;
    bit     exp_to    = 0;
    int     samples[$];
    int     strobes   = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, now);
        end
    endtask

    function automatic void measure(input int k);
`ifdef TIMEBASE_PHASE_METER_AVERAGE_EN
        int s = 0;
        samples.push_back(k);
        if (samples.size() == 4) begin
            foreach (samples[i]) s += samples[i];
            exp_delay = s / 4;
            exp_valid = 1;
            samples.delete();
        end
`else
        exp_delay = k;
        exp_valid = 1;
`endif
    endfunction

    function automatic void model_step(input bit rs, input bit en, input bit r,
                                       input bit l, input int md);
        longint k;
        exp_valid = 0;
        exp_to    = 0;
        if (!rs) begin
            armed = 0; exp_delay = 0; samples.delete();
        end else if (!en) begin
            armed = 0; samples.delete();
        end else if (!armed) begin
            if (r && l) measure(0);
            else if (r) begin armed = 1; t_ref = now; end
        end else begin
            k = now - t_ref;
            if (l) begin
                measure(int'(k));
                if (r) t_ref = now; else armed = 0;
            end else if (r) begin
                t_ref = now;
            end else if (k >= md) begin
                exp_to = 1; armed = 0; samples.delete();
            end
        end
        now++;
    endfunction

    task automatic cyc(input bit rs, input bit en, input bit r, input bit l, input int md);
        rst_n          = rs;
        bus.enable     = en;
        bus.ref_sync   = r;
        bus.local_sync = l;
        bus.max_delay  = CW'(md);
        @(posedge clk);
        model_step(rs, en, r, l, md);
        @(negedge clk);
        if (bus.delay_valid) strobes++;
        chk("delay_out", bus.delay_out, exp_delay);
        chk("delay_valid", bus.delay_valid, exp_valid);
        chk("timeout", bus.timeout, exp_to);
    endtask

    task automatic idle(input int n, input int md);
        for (int i = 0; i < n; i++) cyc(1, 1, 0, 0, md);
    endtask

    // ref_sync, then local_sync k cycles later (k >= 1)
    task automatic meas(input int k, input int md);
        cyc(1, 1, 1, 0, md);
        for (int i = 1; i < k; i++) cyc(1, 1, 0, 0, md);
        cyc(1, 1, 0, 1, md);
    endtask

    int s0;

    initial begin
        @(negedge clk);
        // 1: reset and quiet period
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 100);
        s0 = strobes;
        idle(20, 100);
        chk("t1_no_strobe", strobes - s0, 0);

        // 2: 37-cycle offset
        idle(10, 100);
        meas(37, 100);
        idle(3, 100);

        // 3: timeout at max_delay=5, then a hit exactly at 5
        cyc(1, 1, 1, 0, 5);
        idle(8, 5);
        meas(5, 5);
        idle(2, 5);

        // 4: coincident syncs, and a restart by a second ref_sync
        cyc(1, 1, 1, 1, 50);
        idle(2, 50);
        cyc(1, 1, 1, 0, 50);
        idle(3, 50);
        cyc(1, 1, 1, 0, 50);
        idle(2, 50);
        cyc(1, 1, 0, 1, 50);
        idle(2, 50);

        // 5: enable drop mid-count, reset mid-count
        cyc(1, 1, 1, 0, 50);
        idle(2, 50);
        s0 = strobes;
        cyc(1, 0, 0, 0, 50);
        cyc(1, 1, 0, 0, 50);
        cyc(1, 1, 0, 1, 50);
        idle(2, 50);
        chk("t5_enable_drop_no_strobe", strobes - s0, 0);
        cyc(1, 1, 1, 0, 50);
        idle(3, 50);
        cyc(0, 1, 0, 0, 50);
        cyc(1, 1, 0, 1, 50);
        idle(2, 50);

        // 6: four measurements
        s0 = strobes;
        meas(10, 100); idle(2, 100);
        meas(11, 100); idle(2, 100);
        meas(12, 100); idle(2, 100);
        meas(14, 100); idle(2, 100);
`ifdef TIMEBASE_PHASE_METER_AVERAGE_EN
        chk("t6_strobes", strobes - s0, 1);
`else
        chk("t6_strobes", strobes - s0, 4);
`endif

        // max_delay==0 edge
        cyc(1, 1, 1, 0, 0);
        idle(3, 0);

        // random traffic
        begin
            int md = 20;
            for (int i = 0; i < 4000; i++) begin
                bit rs, en, r, l;
                if ($urandom_range(0, 63) == 0) md = $urandom_range(0, 40);
                rs = ($urandom_range(0, 499) != 0);
                en = ($urandom_range(0, 99) != 0);
                r  = ($urandom_range(0, 15) == 0);
                l  = ($urandom_range(0, 11) == 0);
                cyc(rs, en, r, l, md);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/timebase_phase_meter.md
Name: timebase_phase_meter

Overview:
Measures the phase offset, in clock cycles, between a reference timebase sync pulse and a local timebase sync pulse. The result is presented in the same units and width as the delay value loaded into the timebase shifter, so a controller can read it and correct the shifter's delay directly. The block sits alongside the PWM generator timebase chain as the measurement counterpart of the shifter.

Parameters:
COUNTER_WIDTH, 16, width of the internal delay counter, max_delay and delay_out

Ports:
clockIn  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-low reset
enable  input  1  measurement enable; low forces IDLE
ref_sync  input  1  single-cycle reference timebase sync pulse
local_sync  input  1  single-cycle local timebase sync pulse
max_delay  input  COUNTER_WIDTH  timeout limit in cycles; sampled every cycle
delay_out  output  COUNTER_WIDTH  last valid measured delay, registered
delay_valid  output  1  one-cycle strobe: delay_out updated
timeout  output  1  one-cycle strobe: no local_sync within max_delay

Behaviour:
- Reset (reset==0 at a clock edge): state=IDLE, count=0, delay_out=0, delay_valid=0, timeout=0. Reset applies mid-measurement: any partial count is discarded.
- delay_valid and timeout default to 0 every cycle; each is high for exactly one cycle per event.
- Delay definition: ref_sync in cycle n and local_sync in cycle n+k gives delay_out=k. delay_out and delay_valid change at the edge ending cycle n+k, so they are visible in cycle n+k+1 (latency 1).
- FSM states: IDLE, COUNTING.
- IDLE, enable=1, ref_sync=1, local_sync=0: go to COUNTING, count<=1.
- IDLE, ref_sync=1, local_sync=1 in the same cycle: delay_out<=0, delay_valid<=1, stay IDLE.
- IDLE, local_sync alone: ignored.
- COUNTING, local_sync=1: delay_out<=count, delay_valid<=1.
  - If ref_sync is also 1 in that cycle: stay COUNTING, count<=1 (re-arm).
  - Otherwise: go to IDLE, count<=0.
- COUNTING, ref_sync=1, local_sync=0: restart; count<=1, stay COUNTING, no strobe.
- COUNTING, count==max_delay, no local_sync: timeout<=1, go to IDLE, delay_out holds.
  - local_sync in the same cycle takes priority over timeout: the measurement of max_delay is valid.
- COUNTING, otherwise: count<=count+1. Arithmetic is unsigned; the counter never wraps because the timeout fires first.
- max_delay==0: any COUNTING cycle without local_sync times out immediately.
- enable=0: next state IDLE, count<=0, no strobes. delay_out holds its value.

Optional Feature:
TIMEBASE_PHASE_METER_AVERAGE_EN
- Defined:
  - Valid measurements accumulate into a COUNTER_WIDTH+2 bit sum with a 2-bit sample counter.
  - On every 4th valid measurement: delay_out<=(sum+current)>>2 (truncating), delay_valid strobes, then the accumulator and sample counter clear.
  - Intermediate measurements produce no strobe.
  - A timeout, enable=0 or reset clears the accumulator and sample counter.
- Undefined: every valid measurement updates delay_out and strobes delay_valid, as in Behaviour.

Test Plan:
1. Reset held low 3 cycles, then released; no syncs applied -> delay_out=0, delay_valid=0, timeout=0, and delay_valid stays 0 for 20 cycles.
2. max_delay=100, ref_sync at cycle 10, local_sync at cycle 47 -> delay_out=37 with a single delay_valid strobe visible in cycle 48.
3. max_delay=5, ref_sync with no local_sync -> timeout strobe once, visible 6 cycles after ref_sync (5 increments to reach count==max_delay, plus 1 cycle register latency); delay_out unchanged. Repeat with local_sync exactly 5 cycles after ref_sync -> delay_out=5, no timeout.
4. Simultaneous ref_sync and local_sync in IDLE -> delay_out=0 with a strobe. ref_sync at cycle 0, ref_sync again at cycle 4, local_sync at cycle 7 -> delay_out=3.
5. ref_sync, then enable dropped 3 cycles later, then local_sync -> no strobe, state IDLE. Reset pulse mid-count -> delay_out=0 and the pending measurement is lost.
6. AVERAGE_EN build: measurements 10, 11, 12, 14 -> only one strobe, with delay_out=11; without the macro -> four strobes with delay_out 10, 11, 12, 14 in turn.
